// File: rtl/add_issue_ctrl_if.sv
// Request/response handshake bundle for add_issue_ctrl.
// Optional macro ADD_ISSUE_SUB_EN adds the in_sub request bit.
interface add_issue_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_A;
    logic [N-1:0] in_B;
    logic         in_Cin;
`ifdef ADD_ISSUE_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out_sum;
    logic         out_ovf;

`ifdef ADD_ISSUE_SUB_EN
    modport master (
        output in_valid, in_A, in_B, in_Cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
    modport slave (
        input  in_valid, in_A, in_B, in_Cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
`else
    modport master (
        output in_valid, in_A, in_B, in_Cin, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
    modport slave (
        input  in_valid, in_A, in_B, in_Cin, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
`endif
endinterface

// File: rtl/add_issue_ctrl.sv
// Issue/settle/capture sequencer around an N-bit ripple-carry adder.
// Optional macro ADD_ISSUE_SUB_EN: in_sub selects A-B (B inverted, Cin forced to 1).
module add_issue_ctrl #(
    parameter int unsigned N      = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    add_issue_ctrl_if.slave bus,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic         Cin,
    input  logic [N-1:0] sum,
    input  logic         Cout
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic         cin_q, cin_d;
    logic [N:0]   sum_q, sum_d;
    logic         ovf_q, ovf_d;

    logic [N-1:0] b_in;
    logic         cin_in;
    logic         accept;

    // Operand conditioning applied at accept time
`ifdef ADD_ISSUE_SUB_EN
    always_comb begin
        b_in   = bus.in_sub ? ~bus.in_B : bus.in_B;
        cin_in = bus.in_sub ? 1'b1 : bus.in_Cin;
    end
`else
    always_comb begin
        b_in   = bus.in_B;
        cin_in = bus.in_Cin;
    end
`endif

    assign accept = bus.in_valid && (state_q == StIdle);

    // Next-state and datapath update; operands are only rewritten on accept
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = bus.in_A;
                    b_d     = b_in;
                    cin_d   = cin_in;
                    cnt_d   = 4'(SETTLE - 1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sum_d   = {Cout, sum};
                    // Overflow judged on the operands as actually presented to the adder
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode directly from state
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StHold);
        bus.out_sum   = sum_q;
        bus.out_ovf   = ovf_q;
        A             = a_q;
        B             = b_q;
        Cin           = cin_q;
    end

endmodule

// File: tb/tb_add_issue_ctrl.sv
// Scoreboard bench for add_issue_ctrl with a behavioural adder.
module tb_add_issue_ctrl;
    localparam int unsigned N      = 8;
    localparam int unsigned SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] A, B, sum;
    logic         Cin, Cout;
    logic         sub_sel = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [N+1:0] sb[$];

    add_issue_ctrl_if #(.N(N)) bus ();

    add_issue_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .sum  (sum),
        .Cout (Cout)
    );

    // Ripple-carry adder stand-in
    assign {Cout, sum} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};

    always #5 clk = ~clk;

`ifdef ADD_ISSUE_SUB_EN
    assign bus.in_sub = sub_sel;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {ovf, Cout, sum}
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic c, input logic s);
        logic [N-1:0] bb;
        logic         cc;
        logic [N:0]   r;
        logic         ov;
        bb = s ? ~b : b;
        cc = s ? 1'b1 : c;
        r  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, cc};
        ov = (a[N-1] == bb[N-1]) && (r[N-1] != a[N-1]);
        return {ov, r};
    endfunction

    // Scoreboard: push on accept, pop on result handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_A, bus.in_B, bus.in_Cin, sub_sel));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [N+1:0] e;
                    e = sb.pop_front();
                    check_eq("out_sum", 32'(bus.out_sum), 32'(e[N:0]));
                    check_eq("out_ovf", 32'(bus.out_ovf), 32'(e[N+1]));
                end
            end
        end
    end

    // Present a request and return just after the accepting edge
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input logic s, output logic ok);
        int n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_A     = a;
        bus.in_B     = b;
        bus.in_Cin   = c;
        sub_sel      = s;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = bus.in_ready;
        if (!ok) begin
            check_eq("in_ready_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Full transaction with out_ready high: operand, latency and pulse-width checks
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           input logic s);
        logic ok;
        logic [N-1:0] bb;
        bb = s ? ~b : b;
        bus.out_ready = 1'b1;
        send(a, b, c, s, ok);
        if (ok) begin
            check_eq("reg_A", 32'(A), 32'(a));
            check_eq("reg_B", 32'(B), 32'(bb));
            check_eq("reg_Cin", 32'(Cin), 32'(s ? 1'b1 : c));
            repeat (SETTLE) begin
                @(negedge clk);
                check_eq("lat_early", 32'(bus.out_valid), 32'd0);
            end
            @(negedge clk);
            check_eq("lat_valid", 32'(bus.out_valid), 32'd1);
            @(negedge clk);
            check_eq("valid_drop", 32'(bus.out_valid), 32'd0);
        end
    endtask

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         ok;
        logic [N:0]   held;
        logic [N-1:0] prev_a;
        int           n;

        bus.in_valid  = 1'b0;
        bus.in_A      = '0;
        bus.in_B      = '0;
        bus.in_Cin    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with noisy inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom);
            bus.in_A      = N'($urandom);
            bus.in_B      = N'($urandom);
            bus.in_Cin    = 1'($urandom);
            bus.out_ready = 1'($urandom);
        end
        #1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_A", 32'(A), 32'd0);
        check_eq("rst_B", 32'(B), 32'd0);
        check_eq("rst_Cin", 32'(Cin), 32'd0);
        check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check_eq("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed arithmetic cases; out_sum must also persist after the handshake
        run_txn(8'h25, 8'h17, 1'b0, 1'b0);
        check_eq("add_25_17", 32'(bus.out_sum), 32'h03C);
        check_eq("ovf_25_17", 32'(bus.out_ovf), 32'd0);
        run_txn(8'hFF, 8'h01, 1'b1, 1'b0);
        check_eq("add_ff_01_c", 32'(bus.out_sum), 32'h101);
        check_eq("ovf_ff_01_c", 32'(bus.out_ovf), 32'd0);
        run_txn(8'h7F, 8'h01, 1'b0, 1'b0);
        check_eq("add_7f_01", 32'(bus.out_sum), 32'h080);
        check_eq("ovf_7f_01", 32'(bus.out_ovf), 32'd1);
        run_txn(8'h80, 8'h80, 1'b0, 1'b0);
        check_eq("add_80_80", 32'(bus.out_sum), 32'h100);
        check_eq("ovf_80_80", 32'(bus.out_ovf), 32'd1);

        // Backpressure: result held, pending request not taken
        bus.out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0, ok);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_valid_seen", 32'(bus.out_valid), 32'd1);
        held   = bus.out_sum;
        prev_a = A;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_A     = 8'h44;
        bus.in_B     = 8'h05;
        bus.in_Cin   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_sum_stable", 32'(bus.out_sum), 32'(held));
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("bp_no_capture", 32'(A), 32'(prev_a));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_idle_ready", 32'(bus.in_ready), 32'd1);
        check_eq("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq("bp_pending_A", 32'(A), 32'h44);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_pending_sum", 32'(bus.out_sum), 32'h04A);
        @(negedge clk);

        // Reset one cycle into SETTLE discards the transaction
        send(8'h33, 8'h44, 1'b0, 1'b0, ok);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_A", 32'(A), 32'd0);
        check_eq("mid_rst_sum", 32'(bus.out_sum), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_rst_hold", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(8'h10, 8'h20, 1'b0, 1'b0);
        check_eq("post_rst_sum", 32'(bus.out_sum), 32'h030);

`ifdef ADD_ISSUE_SUB_EN
        run_txn(8'h05, 8'h03, 1'b0, 1'b1);
        check_eq("sub_B", 32'(B), 32'hFC);
        check_eq("sub_Cin", 32'(Cin), 32'd1);
        check_eq("sub_05_03", 32'(bus.out_sum), 32'h102);
        run_txn(8'h80, 8'h01, 1'b0, 1'b1);
        check_eq("sub_ovf_80_01", 32'(bus.out_ovf), 32'd1);
`endif

        // Random traffic through the scoreboard
        for (int i = 0; i < 16; i++) begin
`ifdef ADD_ISSUE_SUB_EN
            run_txn(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
`else
            run_txn(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
`endif
        end

        @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
